// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one outstanding EXU access driven onto the memory responder port.
// Optional LSU_STAT_EN adds load/store/wait statistics counters.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [63:0] mem_addr,
    output logic [3:0]  mem_len,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_valid
`ifdef LSU_STAT_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_wait
`endif
);

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_rw_q, mem_rw_d;
    logic [DW-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]      mem_len_q, mem_len_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            misaligned_c;
    logic [CW-1:0]   cnt_inc_c;
`ifdef LSU_STAT_EN
    logic [31:0]     stat_loads_q, stat_loads_d;
    logic [31:0]     stat_stores_q, stat_stores_d;
    logic [31:0]     stat_wait_q, stat_wait_d;
`endif

    // Sign/zero extension of LSB-aligned load data to 64 bits.
    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] d, input logic [1:0] sz,
                                               input logic uns);
        logic [DW-1:0] r;
        case (sz)
            2'd0:    r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'd1:    r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] store_mask(input logic [DW-1:0] d, input logic [1:0] sz);
        logic [DW-1:0] r;
        case (sz)
            2'd0:    r = {56'b0, d[7:0]};
            2'd1:    r = {48'b0, d[15:0]};
            2'd2:    r = {32'b0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        case (req_size)
            2'd0:    misaligned_c = 1'b0;
            2'd1:    misaligned_c = req_addr[0];
            2'd2:    misaligned_c = |req_addr[1:0];
            default: misaligned_c = |req_addr[2:0];
        endcase
    end

    assign cnt_inc_c = cnt_q + CW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_len_d    = mem_len_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        uns_d        = uns_q;
`ifdef LSU_STAT_EN
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_wait_d   = (state_q == WAIT) ? stat_wait_q + 32'd1 : stat_wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    if (misaligned_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = req_store;
                        mem_addr_d  = req_addr;
                        mem_len_d   = 4'd1 << req_size;
                        mem_wdata_d = store_mask(req_wdata, req_size);
                    end
                end
            end
            // Responder valid may be stale here, so it is not sampled.
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_inc_c;
                if (mem_valid) begin
                    state_d      = RESP;
                    mem_en_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_rw_q ? '0 : load_ext(mem_rdata, size_q, uns_q);
`ifdef LSU_STAT_EN
                    if (mem_rw_q) stat_stores_d = stat_stores_q + 32'd1;
                    else          stat_loads_d  = stat_loads_q + 32'd1;
`endif
                end else if (cnt_inc_c == TIMEOUT_C) begin
                    state_d      = RESP;
                    mem_en_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
            mem_wdata_q  <= '0;
            cnt_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
`ifdef LSU_STAT_EN
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_wait_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_len_q    <= mem_len_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
`ifdef LSU_STAT_EN
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_wait_q   <= stat_wait_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_len    = mem_len_q;
    assign mem_wdata  = mem_wdata_q;
`ifdef LSU_STAT_EN
    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed scoreboard bench for lsu_mem_initiator, built with TIMEOUT=4.
module tb_lsu_mem_initiator;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_rw;
    logic [63:0] mem_addr;
    logic [3:0]  mem_len;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
`ifdef LSU_STAT_EN
    logic [31:0] stat_loads, stat_stores, stat_wait;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          en_pulses = 0;
    logic [64:0] sb[$];

    logic [1:0]  t_sz [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic        t_un [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] t_ad [5] = '{64'h8000_0042, 64'h8000_0044, 64'h8000_0048,
                              64'h8000_0041, 64'h8000_0046};
    logic [63:0] t_rd [5] = '{64'h0000_0000_0000_8000, 64'h0000_0000_8000_0000,
                              64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEFF,
                              64'h0000_0000_ABCD_8001};
    logic [63:0] t_ex [5] = '{64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_8000_0000,
                              64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_00FF,
                              64'h0000_0000_0000_8001};

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_en === 1'b1) en_pulses <= en_pulses + 1;

    lsu_mem_initiator #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef LSU_STAT_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_wait(stat_wait)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one request and returns in the cycle after acceptance.
    task automatic send(input logic st, input logic [63:0] a, input logic [1:0] sz,
                        input logic u, input logic [63:0] wd);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("send_ready", {63'b0, req_ready}, 64'd1);
        req_store = st; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input logic [63:0] rd, input logic e);
        sb.push_back({e, rd});
    endtask

    // Waits for a response, stalls it for 'hold' cycles, then pops and compares.
    task automatic get_resp(input int hold);
        int n = 0;
        logic [64:0] ex;
        while (resp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("resp_arrive", {63'b0, resp_valid}, 64'd1);
        ex = (sb.size() != 0) ? sb.pop_front() : {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < hold; i++) begin
            chk("hold_rdata", resp_rdata, ex[63:0]);
            chk("hold_valid", {63'b0, resp_valid}, 64'd1);
            tick();
        end
        chk("resp_rdata", resp_rdata, ex[63:0]);
        chk("resp_err", {63'b0, resp_err}, {63'b0, ex[64]});
        chk("resp_req_ready_low", {63'b0, req_ready}, 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_drop", {63'b0, resp_valid}, 64'd0);
        chk("req_ready_back", {63'b0, req_ready}, 64'd1);
    endtask

    initial begin
        int p;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_en", {63'b0, mem_en}, 64'd0);
        chk("rst_mem_rw", {63'b0, mem_rw}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_len", {60'b0, mem_len}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        reset = 1'b1;
        tick();

        // Signed byte load, completion in the second WAIT cycle.
        send(1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'h0);
        expect_resp(64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        chk("lb_mem_en", {63'b0, mem_en}, 64'd1);
        chk("lb_mem_len", {60'b0, mem_len}, 64'd1);
        chk("lb_mem_rw", {63'b0, mem_rw}, 64'd0);
        chk("lb_mem_addr", mem_addr, 64'h8000_0003);
        tick();
        chk("lb_wait1_en", {63'b0, mem_en}, 64'd1);
        chk("lb_wait1_valid", {63'b0, resp_valid}, 64'd0);
        tick();
        mem_rdata = 64'h0000_0000_0000_00F0;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("lb_en_drop", {63'b0, mem_en}, 64'd0);
        get_resp(0);

        // Half store: masked write data, zero response data.
        send(1'b1, 64'h8000_0002, 2'd1, 1'b0, 64'h1122_3344_5566_7788);
        expect_resp(64'h0, 1'b0);
        chk("sh_mem_rw", {63'b0, mem_rw}, 64'd1);
        chk("sh_mem_len", {60'b0, mem_len}, 64'd2);
        chk("sh_mem_wdata", mem_wdata, 64'h7788);
        tick();
        mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        get_resp(0);

        // Misaligned word load: error response with no memory access.
        p = en_pulses;
        send(1'b0, 64'h8000_0006, 2'd2, 1'b0, 64'h0);
        expect_resp(64'h0, 1'b1);
        chk("mis_direct_resp", {63'b0, resp_valid}, 64'd1);
        get_resp(0);
        tick();
        chk("mis_no_en", 64'(en_pulses), 64'(p));

        // Timeout: responder never completes.
        send(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'h0);
        mem_rdata = 64'h5555_6666_7777_8888;
        expect_resp(64'h0, 1'b1);
        for (int i = 0; i < int'(TO); i++) begin
            tick();
            chk("to_wait_valid", {63'b0, resp_valid}, 64'd0);
            chk("to_wait_en", {63'b0, mem_en}, 64'd1);
        end
        tick();
        chk("to_resp_valid", {63'b0, resp_valid}, 64'd1);
        chk("to_en_drop", {63'b0, mem_en}, 64'd0);
        get_resp(0);

        // Stale mem_valid during ISSUE must be ignored.
        send(1'b0, 64'h8000_0020, 2'd3, 1'b0, 64'h0);
        expect_resp(64'h0123_4567_89AB_CDEF, 1'b0);
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("stale_no_resp", {63'b0, resp_valid}, 64'd0);
        chk("stale_still_en", {63'b0, mem_en}, 64'd1);
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        get_resp(0);

        // Extension table.
        for (int i = 0; i < 5; i++) begin
            send(1'b0, t_ad[i], t_sz[i], t_un[i], 64'h0);
            expect_resp(t_ex[i], 1'b0);
            chk("tbl_len", {60'b0, mem_len}, 64'd1 << t_sz[i]);
            tick();
            mem_rdata = t_rd[i];
            mem_valid = 1'b1;
            tick();
            mem_valid = 1'b0;
            get_resp(0);
        end

        // Unsigned word load with back-pressure; new requests ignored meanwhile.
        send(1'b0, 64'h8000_0008, 2'd2, 1'b1, 64'h0);
        expect_resp(64'h0000_0000_FFFF_FFFF, 1'b0);
        tick();
        mem_rdata = 64'hDEAD_BEEF_FFFF_FFFF;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        req_store = 1'b1; req_addr = 64'h8000_0100; req_size = 2'd3; req_valid = 1'b1;
        tick();
        tick();
        chk("busy_ignored", {63'b0, mem_en}, 64'd0);
        req_valid = 1'b0;
        get_resp(5);

        // Reset in the middle of WAIT abandons the access.
        send(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'h0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rstw_mem_en", {63'b0, mem_en}, 64'd0);
        chk("rstw_resp_valid", {63'b0, resp_valid}, 64'd0);
        reset = 1'b1;
        tick();
        chk("rstw_req_ready", {63'b0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw_no_resp", {63'b0, resp_valid}, 64'd0);
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
